// File: rtl/game_pkg.sv
// Shared types and constants for the game clock display path.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index n holds the code for digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code, with a blanking override.
// Purely combinational; the parent registers the result.
module seg7_decode
    import game_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg_c = SEG_DIGIT[0];
                4'd1:    seg_c = SEG_DIGIT[1];
                4'd2:    seg_c = SEG_DIGIT[2];
                4'd3:    seg_c = SEG_DIGIT[3];
                4'd4:    seg_c = SEG_DIGIT[4];
                4'd5:    seg_c = SEG_DIGIT[5];
                4'd6:    seg_c = SEG_DIGIT[6];
                4'd7:    seg_c = SEG_DIGIT[7];
                4'd8:    seg_c = SEG_DIGIT[8];
                4'd9:    seg_c = SEG_DIGIT[9];
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/time_display.sv
// Tenths-of-a-second count to BCD (sequential double-dabble) and four
// active-low 7-segment displays showing SSS.T with leading-zero blanking.
module time_display
    import game_pkg::*;
#(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned DIGITS = NUM_DIGITS
) (
    input  logic                  CLOCK10M,
    input  logic                  KEY0,
    input  logic [CNT_W-1:0]      counter_in,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    output logic                  busy,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX0
);

    localparam int unsigned FIELD_W = 4 * DIGITS;
    localparam int unsigned SR_W    = FIELD_W + CNT_W;
    localparam int unsigned ITER_W  = $clog2(CNT_W);

    state_t              state;
    logic [CNT_W-1:0]    in_q;
    logic [CNT_W-1:0]    last_val;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     sr_adj;
    logic [ITER_W-1:0]   iter;
    logic [FIELD_W-1:0]  field;
    logic [3:0]          dig3;
    logic [3:0]          dig2;
    logic [3:0]          dig1;
    logic [3:0]          dig0;
    logic                blank3;
    logic                blank2;
    logic [6:0]          seg3_c;
    logic [6:0]          seg2_c;
    logic [6:0]          seg1_c;
    logic [6:0]          seg0_c;

    assign field  = sr[SR_W-1:CNT_W];
    assign dig3   = field[12 +: 4];
    assign dig2   = field[8 +: 4];
    assign dig1   = field[4 +: 4];
    assign dig0   = field[0 +: 4];
    assign blank3 = (dig3 == 4'd0);
    assign blank2 = blank3 && (dig2 == 4'd0);

    // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (sr[CNT_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[CNT_W + 4*d +: 4] = sr[CNT_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    seg7_decode u_seg3 (.bcd(dig3), .blank(blank3), .seg_c(seg3_c));
    seg7_decode u_seg2 (.bcd(dig2), .blank(blank2), .seg_c(seg2_c));
    seg7_decode u_seg1 (.bcd(dig1), .blank(1'b0),   .seg_c(seg1_c));
    seg7_decode u_seg0 (.bcd(dig0), .blank(1'b0),   .seg_c(seg0_c));

    // Input capture, conversion FSM and registered display outputs.
    always_ff @(posedge CLOCK10M or negedge KEY0) begin
        if (!KEY0) begin
            state    <= IDLE;
            in_q     <= '0;
            last_val <= '0;
            sr       <= '0;
            iter     <= '0;
            bcd_out  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            HEX3     <= SEG_BLANK;
            HEX2     <= SEG_BLANK;
            HEX1     <= SEG_DIGIT[0];
            HEX0     <= SEG_DIGIT[0];
        end else begin
            in_q  <= counter_in;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if ((in_q != last_val) && !freeze) begin
                        sr       <= SR_W'(in_q);
                        last_val <= in_q;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    sr   <= {sr_adj[SR_W-2:0], 1'b0};
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_W'(CNT_W - 1)) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    bcd_out <= field;
                    HEX3    <= seg3_c;
                    HEX2    <= seg2_c;
                    HEX1    <= seg1_c;
                    HEX0    <= seg0_c;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/time_display.md
# time_display

Downstream display stage for the 0.1 s game counter. Takes the 10-bit tenths count (0–1023, i.e. 0.0–102.3 s) and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives four active-low 7-segment displays showing `SSS.T`. Conversion runs only when the count changes; a freeze input holds the shown value for lap display.

## Interface
Parameters:
- `CNT_W`, default 10: width of the incoming tenths count.
- `DIGITS`, default 4: number of BCD digits and displays.

Ports:
- `CLOCK10M` input, 1: 10 MHz system clock; all state is on the rising edge.
- `KEY0` input, 1: reset, asynchronous, active-low.
- `counter_in` input, CNT_W: tenths count from the game clock stage.
- `freeze` input, 1: active-high; while 1, no new conversion starts.
- `bcd_out` output, 16: digits, from [15:12] (hundreds of seconds) down to [3:0] (tenths).
- `valid` output, 1: one-cycle pulse when `bcd_out` and the HEX outputs update.
- `busy` output, 1: high while the state is CONV or LATCH.
- `HEX3`/`HEX2`/`HEX1`/`HEX0` output, 7 each: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- `counter_in` is registered into `in_q` every cycle. This is a single register stage; the source is in the same clock domain.
- FSM states: IDLE, CONV, LATCH.
- **IDLE:**
  - If `in_q != last_val` and `freeze == 0`: load the shift register with {16'b0, `in_q`}, set `last_val <= in_q`, set `iter <= 0`, go to CONV.
  - Otherwise stay in IDLE.
- **CONV:** each cycle, in this order:
  - add 3 to every BCD nibble that is ≥5;
  - shift the whole register left 1;
  - `iter++`.
  - After the 10th iteration (`iter == CNT_W-1` at the edge), go to LATCH.
- **LATCH:**
  - Register the BCD field into `bcd_out` and the decoded segment codes into `HEX3..0`.
  - Pulse `valid` for 1 cycle and return to IDLE.
- Segment codes for digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank is 1111111.
- Leading-zero blanking:
  - HEX3 is blank if digit3 == 0.
  - HEX2 is blank if digit3 == 0 and digit2 == 0.
  - HEX1 and HEX0 are always shown.
- A `counter_in` change during CONV/LATCH is not lost. On return to IDLE the comparison runs against the newest `in_q`, and a new conversion starts if it differs.
- Asserting `freeze` mid-conversion does not abort it; the conversion completes and its result is shown. Releasing `freeze` lets the pending difference convert.
- Input values above 1023 cannot occur (CNT_W = 10). BCD digit3 is at most 1.

## Timing
- **Reset values:**
  - state IDLE, `in_q` = 0, `last_val` = 0, `bcd_out` = 0, `valid` = 0, `busy` = 0;
  - HEX3 and HEX2 = 1111111 (blank), HEX1 = HEX0 = 1000000 (display shows "0.0").
- **Latency:**
  - edge E0: `in_q` captures the new value;
  - E1: IDLE loads;
  - E2–E11: 10 CONV iterations;
  - E12: LATCH updates the outputs, and `valid` is high from E12 to E13.
  - Total: 13 edges from a `counter_in` change to the outputs updating.
- Minimum spacing between updates is 12 cycles. The game counter changes every 1 000 000 cycles, so every change is displayed.
- `KEY0` low mid-conversion: all registers return to their reset values immediately. The partial result is discarded and the display shows "0.0".
- The outputs are stable between `valid` pulses.

## Structure
- Shared package `game_pkg`:
  - state enum {IDLE, CONV, LATCH};
  - `SEG_BLANK` and the ten `SEG_DIGIT` constants;
  - `BCD_W = 4*DIGITS`.
- Sub-module `seg7_decode`: 4-bit BCD input and blank input → 7-bit active-low segments. Purely combinational, instantiated 4 times; its outputs are registered in LATCH.
- The double-dabble shift register (`BCD_W + CNT_W` bits) and the FSM stay in `time_display`.

## Test plan
- Release reset with `counter_in` = 0 → no `valid` pulse; HEX3..0 = 1111111, 1111111, 1000000, 1000000.
- `counter_in` 0→123 at cycle 100 → `valid` at the 13th edge after the change; `bcd_out` = 0x0123; HEX3 blank, HEX2 = 1111001, HEX1 = 0100100, HEX0 = 0110000.
- `counter_in` = 1023 → `bcd_out` = 0x1023; HEX3 = 1111001, HEX2 = 1000000, HEX1 = 0100100, HEX0 = 0110000. `counter_in` = 7 → `bcd_out` = 0x0007; HEX3 and HEX2 blank, HEX1 = 1000000.
- `counter_in` = 5 then 6 at E3 (mid-conversion) → first `valid` shows 0x0005; a second `valid` 12 edges later shows 0x0006.
- `freeze` = 1, then `counter_in` 50→51 → no `valid`, display stays 0x0050. `freeze` = 0 → `valid` within 12 edges with 0x0051.
- `KEY0` low at E6 of a conversion of 999 → `busy` = 0 and HEX outputs at reset values immediately. After release with `counter_in` = 999 → a fresh conversion yields 0x0999.
